// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage with a single outstanding data-memory request
//
// Purpose: passes ALU results through to write-back in one cycle. Load/store
// instructions whose condition holds are sent to data memory, and the stage
// stalls until the memory acknowledges.
//
// Optional feature: define MEM_TIMEOUT_EN to abandon an unacknowledged access
// after 255 WAIT cycles. The instruction is then annulled and mem_fault pulses.
//
// Ports:
//   clk, reset                    clock; synchronous active-high reset
//   ex_valid, ex_instruction,     instruction and operands from execute
//   ex_conditionBool, ex_alu_out,
//   ex_base, ex_store_data
//   dmem_req/we/addr/wdata        data-memory request (registered, held during WAIT)
//   dmem_ack, dmem_rdata          data-memory response
//   wb_valid, instruction,        registered results to write-back
//   conditionBool, LS, alu_out,
//   Dmem_out, wb
//   mem_stall                     high while an access is outstanding
//   mem_fault                     one-cycle pulse on access timeout
module mem_access (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] ex_instruction,
   input  logic        ex_conditionBool,
   input  logic [15:0] ex_alu_out,
   input  logic [15:0] ex_base,
   input  logic [15:0] ex_store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] instruction,
   output logic        conditionBool,
   output logic        LS,
   output logic [15:0] alu_out,
   output logic [15:0] Dmem_out,
   output logic [15:0] wb,
   output logic        mem_stall,
   output logic        mem_fault
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic        wb_valid_q, wb_valid_d;
   logic [31:0] instr_q, instr_d;
   logic        cond_q, cond_d;
   logic        ls_q, ls_d;
   logic [15:0] alu_q, alu_d;
   logic [15:0] dout_q, dout_d;
   logic [15:0] wb_q, wb_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        load_q, load_d;
   logic        fault_q, fault_d;
`ifdef MEM_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d;
`endif

   logic is_ls, is_load, is_pre;

   assign is_ls   = (ex_instruction[27:26] == 2'b01);
   assign is_load = ex_instruction[20];
   assign is_pre  = ex_instruction[24];

   always_comb begin
      state_d    = state_q;
      wb_valid_d = 1'b0;
      instr_d    = instr_q;
      cond_d     = cond_q;
      ls_d       = ls_q;
      alu_d      = alu_q;
      dout_d     = dout_q;
      wb_d       = wb_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      load_d     = load_q;
      fault_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               instr_d = ex_instruction;
               cond_d  = ex_conditionBool;
               ls_d    = is_ls;
               alu_d   = ex_alu_out;
               wb_d    = ex_alu_out;
               if (is_ls && ex_conditionBool) begin
                  state_d = ST_WAIT;
                  req_d   = 1'b1;
                  we_d    = ~is_load;
                  addr_d  = is_pre ? ex_alu_out : ex_base;
                  wdata_d = is_load ? 16'h0000 : ex_store_data;
                  load_d  = is_load;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = 8'd0;
`endif
               end else begin
                  wb_valid_d = 1'b1;
                  dout_d     = 16'h0000;
               end
            end
         end
         default: begin
            if (dmem_ack) begin
               dout_d     = load_q ? dmem_rdata : 16'h0000;
               wb_valid_d = 1'b1;
               req_d      = 1'b0;
               state_d    = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
            end else if (cnt_q == 8'd254) begin
               // The 255th WAIT cycle without an ack abandons the access.
               req_d      = 1'b0;
               state_d    = ST_IDLE;
               wb_valid_d = 1'b1;
               cond_d     = 1'b0;
               dout_d     = 16'h0000;
               fault_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wb_valid_q <= 1'b0;
         instr_q    <= 32'h0;
         cond_q     <= 1'b0;
         ls_q       <= 1'b0;
         alu_q      <= 16'h0;
         dout_q     <= 16'h0;
         wb_q       <= 16'h0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 16'h0;
         wdata_q    <= 16'h0;
         load_q     <= 1'b0;
         fault_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         wb_valid_q <= wb_valid_d;
         instr_q    <= instr_d;
         cond_q     <= cond_d;
         ls_q       <= ls_d;
         alu_q      <= alu_d;
         dout_q     <= dout_d;
         wb_q       <= wb_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         load_q     <= load_d;
         fault_q    <= fault_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_wdata    = wdata_q;
   assign wb_valid      = wb_valid_q;
   assign instruction   = instr_q;
   assign conditionBool = cond_q;
   assign LS            = ls_q;
   assign alu_out       = alu_q;
   assign Dmem_out      = dout_q;
   assign wb            = wb_q;
   assign mem_stall     = (state_q == ST_WAIT);
`ifdef MEM_TIMEOUT_EN
   assign mem_fault     = fault_q;
`else
   assign mem_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [31:0] ex_instruction;
   logic        ex_conditionBool;
   logic [15:0] ex_alu_out, ex_base, ex_store_data;
   logic        dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic        wb_valid;
   logic [31:0] instruction;
   logic        conditionBool, LS;
   logic [15:0] alu_out, Dmem_out, wb;
   logic        mem_stall, mem_fault;

   int total = 0;
   int bad   = 0;

   mem_access dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_instruction(ex_instruction),
      .ex_conditionBool(ex_conditionBool), .ex_alu_out(ex_alu_out),
      .ex_base(ex_base), .ex_store_data(ex_store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .instruction(instruction),
      .conditionBool(conditionBool), .LS(LS), .alu_out(alu_out),
      .Dmem_out(Dmem_out), .wb(wb), .mem_stall(mem_stall), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [1:0] op, input logic l, input logic w, input logic p);
      logic [31:0] v;
      v = $urandom;
      v[27:26] = op;
      v[20] = l;
      v[21] = w;
      v[24] = p;
      return v;
   endfunction

   task automatic present(input logic [31:0] ins, input logic c, input logic [15:0] alu,
                          input logic [15:0] base, input logic [15:0] sd);
      ex_valid = 1'b1;
      ex_instruction = ins;
      ex_conditionBool = c;
      ex_alu_out = alu;
      ex_base = base;
      ex_store_data = sd;
   endtask

   task automatic test_reset();
      reset = 1'b1; ex_valid = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
      ex_instruction = 32'h0400_0000; ex_conditionBool = 1'b1;
      ex_alu_out = 16'h1111; ex_base = 16'h2222; ex_store_data = 16'h3333;
      step(); step();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
      total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin bad++; $display("FAIL reset_dmem_ctl got req=%b we=%b want 0", dmem_req, dmem_we); end
      total++; if (mem_stall !== 1'b0 || mem_fault !== 1'b0) begin bad++; $display("FAIL reset_stall_fault got=%b%b want=00", mem_stall, mem_fault); end
      total++; if ({instruction, alu_out, Dmem_out, wb, dmem_addr, dmem_wdata, conditionBool, LS} !== '0) begin
         bad++; $display("FAIL reset_data got ins=%h alu=%h dout=%h wb=%h addr=%h wd=%h c=%b ls=%b want 0",
                         instruction, alu_out, Dmem_out, wb, dmem_addr, dmem_wdata, conditionBool, LS); end
      reset = 1'b0; ex_valid = 1'b0; dmem_ack = 1'b0;
      step();
   endtask

   task automatic test_alu();
      logic [31:0] ins;
      ins = mk(2'b00, 1'b0, 1'b0, 1'b0);
      present(ins, 1'b1, 16'h1234, 16'h0, 16'h0);
      step();
      ex_valid = 1'b0;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid got=%b want=1", wb_valid); end
      total++; if (alu_out !== 16'h1234 || instruction !== ins) begin bad++; $display("FAIL alu_fields got alu=%h ins=%h want alu=1234 ins=%h", alu_out, instruction, ins); end
      total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || Dmem_out !== 16'h0 || LS !== 1'b0) begin
         bad++; $display("FAIL alu_no_mem got req=%b stall=%b dout=%h ls=%b want 0", dmem_req, mem_stall, Dmem_out, LS); end
      step();
      total++; if (wb_valid !== 1'b0 || alu_out !== 16'h1234) begin bad++; $display("FAIL alu_pulse_hold got v=%b alu=%h want v=0 alu=1234", wb_valid, alu_out); end
      // ack while idle is ignored
      dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
      step();
      dmem_ack = 1'b0;
      total++; if (wb_valid !== 1'b0 || Dmem_out !== 16'h0 || mem_stall !== 1'b0) begin
         bad++; $display("FAIL idle_ack got v=%b dout=%h stall=%b want 0", wb_valid, Dmem_out, mem_stall); end
   endtask

   task automatic test_load();
      logic [31:0] ins;
      int stalls;
      ins = mk(2'b01, 1'b1, 1'b0, 1'b1);
      present(ins, 1'b1, 16'h0040, 16'h0999, 16'h7777);
      step();
      // a different instruction offered during WAIT must be ignored
      present(mk(2'b00, 1'b0, 1'b0, 1'b0), 1'b1, 16'hAAAA, 16'h0, 16'h0);
      total++; if (dmem_req !== 1'b1 || dmem_addr !== 16'h0040 || dmem_we !== 1'b0 || dmem_wdata !== 16'h0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL load_req got req=%b addr=%h we=%b wd=%h v=%b want 1/0040/0/0000/0", dmem_req, dmem_addr, dmem_we, dmem_wdata, wb_valid); end
      stalls = 0;
      for (int i = 0; i < 3; i++) begin
         if (mem_stall === 1'b1 && dmem_addr === 16'h0040 && dmem_req === 1'b1) stalls++;
         if (i == 2) begin ex_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 16'hBEEF; end
         step();
      end
      dmem_ack = 1'b0;
      total++; if (stalls !== 3) begin bad++; $display("FAIL load_stall got=%0d want=3", stalls); end
      total++; if (wb_valid !== 1'b1 || Dmem_out !== 16'hBEEF || wb !== 16'h0040 || instruction !== ins) begin
         bad++; $display("FAIL load_result got v=%b dout=%h wb=%h ins=%h want 1/BEEF/0040/%h", wb_valid, Dmem_out, wb, instruction, ins); end
      total++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL load_release got stall=%b req=%b want 0", mem_stall, dmem_req); end
      step();
   endtask

   task automatic test_store();
      present(mk(2'b01, 1'b0, 1'b1, 1'b0), 1'b1, 16'h0104, 16'h0100, 16'hA5A5);
      step();
      ex_valid = 1'b0;
      total++; if (dmem_addr !== 16'h0100 || dmem_we !== 1'b1 || dmem_wdata !== 16'hA5A5 || dmem_req !== 1'b1) begin
         bad++; $display("FAIL store_req got addr=%h we=%b wd=%h req=%b want 0100/1/A5A5/1", dmem_addr, dmem_we, dmem_wdata, dmem_req); end
      dmem_ack = 1'b1; dmem_rdata = 16'h5555;
      step();
      dmem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb !== 16'h0104 || Dmem_out !== 16'h0 || LS !== 1'b1) begin
         bad++; $display("FAIL store_result got v=%b wb=%h dout=%h ls=%b want 1/0104/0000/1", wb_valid, wb, Dmem_out, LS); end
   endtask

   task automatic test_cond_false();
      present(mk(2'b01, 1'b1, 1'b1, 1'b1), 1'b0, 16'h0200, 16'h0300, 16'h0);
      step();
      ex_valid = 1'b0;
      total++; if (wb_valid !== 1'b1 || conditionBool !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
         bad++; $display("FAIL cond_false got v=%b c=%b req=%b stall=%b want 1/0/0/0", wb_valid, conditionBool, dmem_req, mem_stall); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins2;
      ins2 = mk(2'b10, 1'b0, 1'b0, 1'b0);
      present(mk(2'b01, 1'b1, 1'b0, 1'b1), 1'b1, 16'h0010, 16'h0, 16'h0);
      step();
      ex_valid = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 16'h1357;
      step();
      dmem_ack = 1'b0;
      present(ins2, 1'b1, 16'h2468, 16'h0, 16'h0);
      total++; if (wb_valid !== 1'b1 || Dmem_out !== 16'h1357) begin bad++; $display("FAIL b2b_first got v=%b dout=%h want 1/1357", wb_valid, Dmem_out); end
      step();
      ex_valid = 1'b0;
      total++; if (wb_valid !== 1'b1 || instruction !== ins2 || alu_out !== 16'h2468 || Dmem_out !== 16'h0) begin
         bad++; $display("FAIL b2b_second got v=%b ins=%h alu=%h dout=%h want 1/%h/2468/0000", wb_valid, instruction, alu_out, Dmem_out, ins2); end
      step();
   endtask

   task automatic test_reset_in_wait();
      present(mk(2'b01, 1'b1, 1'b0, 1'b1), 1'b1, 16'h0ABC, 16'h0, 16'h0);
      step();
      ex_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0 || dmem_addr !== 16'h0 || instruction !== 32'h0 || wb !== 16'h0) begin
         bad++; $display("FAIL rst_wait got req=%b stall=%b v=%b addr=%h ins=%h wb=%h want 0", dmem_req, mem_stall, wb_valid, dmem_addr, instruction, wb); end
      dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
      step();
      dmem_ack = 1'b0;
      step();
      total++; if (wb_valid !== 1'b0 || Dmem_out !== 16'h0) begin bad++; $display("FAIL rst_late_ack got v=%b dout=%h want 0/0000", wb_valid, Dmem_out); end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic        c, mem;
      logic [15:0] alu, base, sd, rd, exp_addr, exp_wd, exp_dout;
      int          delay, stalls;
      for (int n = 0; n < 150; n++) begin
         ins  = mk(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
         c    = ($urandom_range(0, 4) != 0);
         alu  = 16'($urandom); base = 16'($urandom); sd = 16'($urandom); rd = 16'($urandom);
         mem  = (ins[27:26] == 2'b01) && c;
         exp_addr = ins[24] ? alu : base;
         exp_wd   = ins[20] ? 16'h0 : sd;
         exp_dout = (mem && ins[20]) ? rd : 16'h0;
         delay    = $urandom_range(1, 4);
         present(ins, c, alu, base, sd);
         step();
         ex_valid = 1'b0;
         if (mem) begin
            total++; if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== ~ins[20] || dmem_wdata !== exp_wd) begin
               bad++; $display("FAIL rnd_req[%0d] got req=%b addr=%h we=%b wd=%h want 1/%h/%b/%h", n, dmem_req, dmem_addr, dmem_we, dmem_wdata, exp_addr, ~ins[20], exp_wd); end
            stalls = 0;
            for (int d = 1; d <= delay; d++) begin
               if (mem_stall === 1'b1 && wb_valid === 1'b0) stalls++;
               if (d == delay) begin dmem_ack = 1'b1; dmem_rdata = rd; end
               step();
            end
            dmem_ack = 1'b0;
            total++; if (stalls !== delay) begin bad++; $display("FAIL rnd_stall[%0d] got=%0d want=%0d", n, stalls, delay); end
         end
         total++; if (wb_valid !== 1'b1 || instruction !== ins || conditionBool !== c || LS !== (ins[27:26] == 2'b01)
                      || alu_out !== alu || wb !== alu || Dmem_out !== exp_dout || mem_stall !== 1'b0) begin
            bad++; $display("FAIL rnd_wb[%0d] got v=%b ins=%h c=%b ls=%b alu=%h wb=%h dout=%h want 1/%h/%b/%b/%h/%h/%h",
                            n, wb_valid, instruction, conditionBool, LS, alu_out, wb, Dmem_out, ins, c, (ins[27:26] == 2'b01), alu, alu, exp_dout); end
         if ($urandom_range(0, 1) == 1) step();
      end
      step();
   endtask

   task automatic test_timeout();
      int n;
      present(mk(2'b01, 1'b1, 1'b0, 1'b1), 1'b1, 16'h0F00, 16'h0, 16'h0);
      step();
      ex_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
      n = 0;
      while (mem_stall === 1'b1 && n < 400) begin n++; step(); end
      total++; if (n !== 255) begin bad++; $display("FAIL to_cycles got=%0d want=255", n); end
      total++; if (wb_valid !== 1'b1 || mem_fault !== 1'b1 || conditionBool !== 1'b0 || dmem_req !== 1'b0) begin
         bad++; $display("FAIL to_fault got v=%b f=%b c=%b req=%b want 1/1/0/0", wb_valid, mem_fault, conditionBool, dmem_req); end
      step();
      total++; if (mem_fault !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL to_pulse got f=%b v=%b want 0/0", mem_fault, wb_valid); end
      present(mk(2'b01, 1'b1, 1'b0, 1'b1), 1'b1, 16'h0F02, 16'h0, 16'h0);
      step();
      ex_valid = 1'b0;
      for (int i = 1; i <= 255; i++) begin
         if (i == 255) begin dmem_ack = 1'b1; dmem_rdata = 16'h4242; end
         step();
      end
      dmem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1 || mem_fault !== 1'b0 || conditionBool !== 1'b1 || Dmem_out !== 16'h4242) begin
         bad++; $display("FAIL to_ack_wins got v=%b f=%b c=%b dout=%h want 1/0/1/4242", wb_valid, mem_fault, conditionBool, Dmem_out); end
      step();
`else
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (mem_stall === 1'b1 && dmem_req === 1'b1 && mem_fault === 1'b0 && wb_valid === 1'b0) n++;
         step();
      end
      total++; if (n !== 300) begin bad++; $display("FAIL hold_wait got=%0d want=300", n); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
`endif
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_cond_false();
      test_back_to_back();
      test_reset_in_wait();
      test_random();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have inputs from execute: ex_valid 1 (instruction present); ex_instruction 32; ex_conditionBool 1; ex_alu_out 16 (result, or effective address for LS); ex_base 16 (Rn value); ex_store_data 16.
REQ-004 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 16; dmem_wdata out 16; dmem_ack in 1; dmem_rdata in 16.
REQ-005 SHALL have outputs to write-back, all registered: wb_valid 1; instruction 32; conditionBool 1; LS 1; alu_out 16; Dmem_out 16; wb 16 (base write-back value).
REQ-006 SHALL have mem_stall out 1 (upstream holds its stage while high) and mem_fault out 1.

Function
REQ-007 LS decode: ex_instruction[27:26]==2'b01; load = bit 20; base write-back = bit 21; pre-index = bit 24.
REQ-008 Access address: pre-index ? ex_alu_out : ex_base; wb output = ex_alu_out always.
REQ-009 States: IDLE, WAIT; mem_stall = (state==WAIT), derived from registered state only.
REQ-010 IDLE, ex_valid, non-LS or ex_conditionBool=0: register all fields, wb_valid=1 next cycle (latency 1), Dmem_out=0, no memory request.
REQ-011 IDLE, ex_valid, LS, ex_conditionBool=1: latch fields, address, store data, we=~bit20; go WAIT; wb_valid=0 next cycle.
REQ-012 WAIT: dmem_req=1, dmem_addr/dmem_wdata/dmem_we held stable from latched values; no new instruction accepted.
REQ-013 WAIT with dmem_ack=1: capture dmem_rdata into Dmem_out if load (else Dmem_out=0); next cycle wb_valid=1, dmem_req=0, state IDLE.
REQ-014 Minimum LS latency: accept cycle 0, req cycle 1, ack cycle 1 -> wb_valid cycle 2.
REQ-015 wb_valid is a one-cycle pulse per instruction; with ex_valid=0 in IDLE, wb_valid=0 and other outputs hold.
REQ-016 dmem_ack while IDLE SHALL be ignored; dmem_ack in the same cycle as the request entering WAIT is not possible (req registered).
REQ-017 dmem_we=0 for loads; dmem_wdata=0 for loads.
REQ-018 All address/data arithmetic is 16-bit, wrap modulo 2^16, no carry outputs.
REQ-019 Back-to-back: instruction presented in cycle of return to IDLE is accepted that cycle.

Reset
REQ-020 reset=1 at any edge: state IDLE; wb_valid, conditionBool, LS, dmem_req, dmem_we, mem_fault = 0; instruction, alu_out, Dmem_out, wb, dmem_addr, dmem_wdata = 0; timeout counter = 0.
REQ-021 Reset during WAIT SHALL drop dmem_req the following cycle and discard the pending access; no wb_valid produced for it.
REQ-022 reset dominates ex_valid and dmem_ack in the same cycle.

Configuration
REQ-023 Macro MEM_TIMEOUT_EN defined: 8-bit counter cleared on entering WAIT, incremented each WAIT cycle without ack; at count 255 without ack: dmem_req=0, state IDLE, wb_valid=1 with conditionBool=0 (annulled), mem_fault=1 for one cycle.
REQ-024 Ack arriving in the same cycle the counter reaches 255 SHALL complete normally (ack wins), no fault.
REQ-025 Macro undefined: no counter, WAIT held indefinitely, mem_fault tied 0.

Verification
REQ-026 ADD (bits27:26=00), cond=1, ex_alu_out=0x1234 -> wb_valid=1 next cycle, alu_out=0x1234, no dmem_req.
REQ-027 Load pre-index (bit20=1, bit24=1), ex_alu_out=0x0040, ack 3 cycles after req, rdata=0xBEEF -> dmem_addr=0x0040, mem_stall high 3 cycles, Dmem_out=0xBEEF, wb=0x0040.
REQ-028 Store post-index (bit20=0, bit24=0, bit21=1), ex_base=0x0100, ex_alu_out=0x0104, store=0xA5A5 -> dmem_addr=0x0100, dmem_we=1, dmem_wdata=0xA5A5, wb=0x0104.
REQ-029 LS with ex_conditionBool=0 -> no dmem_req, wb_valid=1 next cycle with conditionBool=0.
REQ-030 reset asserted 2 cycles into WAIT -> dmem_req=0 next cycle, all outputs zero, later ack ignored.
REQ-031 With MEM_TIMEOUT_EN, no ack -> after 255 WAIT cycles mem_fault pulses 1, wb_valid=1, conditionBool=0; without macro, mem_stall stays high.
